// File: rtl/fg_pkg.sv
// Shared types and limits for the function generator and its sweep sequencer.
package fg_pkg;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    TRIANGLE = 2'd1,
    SQUARE   = 2'd2,
    PWM      = 2'd3
  } signal_t;

  localparam int ST_MAX_COUNT = 9999;
  localparam int SQ_MAX_COUNT = 499999;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_STEP,
    S_DONE
  } sweep_state_t;

endpackage

// File: rtl/fg_dwell_timer.sv
// Dwell down-counter: load a hold length, count down, flag the final cycle.
module fg_dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  // The STEP cycle counts toward the hold, so the dwell ends one count early.
  assign expire = (cnt == DWELL_W'(1));

endmodule

// File: rtl/fg_sweep_ctrl.sv
// Frequency-sweep sequencer driving func_gen set_count/sig_type/duty_cycle.
module fg_sweep_ctrl
  import fg_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int DWELL_W = 24,
  parameter int ST_MAX  = ST_MAX_COUNT,
  parameter int SQ_MAX  = SQ_MAX_COUNT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         cfg_sig_type,
  input  logic [7:0]         cfg_duty,
  input  logic [CNT_W-1:0]   cfg_start_cnt,
  input  logic [CNT_W-1:0]   cfg_stop_cnt,
  input  logic [CNT_W-1:0]   cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_pingpong,
  output logic [CNT_W-1:0]   set_count,
  output logic [1:0]         sig_type,
  output logic [7:0]         duty_cycle,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  sweep_state_t       state, state_nx;
  logic [1:0]         sh_sig;
  logic [7:0]         sh_duty;
  logic [CNT_W-1:0]   sh_start, sh_stop, sh_step;
  logic [DWELL_W-1:0] sh_dwell;
  logic               sh_pp;
  logic               dir_up, dir_nx;
  logic [CNT_W-1:0]   lim, step_val, up_nx, dn_nx;
  logic [CNT_W:0]     sum, diff;
  logic               req, cfg_bad, accept, at_stop, at_start, expire, tmr_load;

  // Validation runs on the live cfg_* inputs; only accepted programs get shadowed.
  assign lim     = (signal_t'(cfg_sig_type) inside {SINE, TRIANGLE}) ? CNT_W'(ST_MAX) : CNT_W'(SQ_MAX);
  assign cfg_bad = (cfg_start_cnt > cfg_stop_cnt) || (cfg_stop_cnt > lim) || (cfg_step == '0);
  assign req     = start && !stop;
  assign accept  = (state == S_IDLE) && req && !cfg_bad;

  // Carry/borrow bit catches wrap so the clamp never lets it reach set_count.
  assign sum      = {1'b0, set_count} + {1'b0, sh_step};
  assign diff     = {1'b0, set_count} - {1'b0, sh_step};
  assign up_nx    = (sum > {1'b0, sh_stop}) ? sh_stop : sum[CNT_W-1:0];
  assign dn_nx    = (diff[CNT_W] || (diff[CNT_W-1:0] < sh_start)) ? sh_start : diff[CNT_W-1:0];
  assign at_stop  = (set_count == sh_stop);
  assign at_start = (set_count == sh_start);

  always_comb begin
    step_val = set_count;
    dir_nx   = dir_up;
    if (dir_up) begin
      if (!at_stop)    step_val = up_nx;
      else if (sh_pp) begin
        dir_nx   = 1'b0;
        step_val = dn_nx;
      end
    end else begin
      if (at_start) begin
        dir_nx   = 1'b1;
        step_val = up_nx;
      end else begin
        step_val = dn_nx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_LOAD;
      S_LOAD:  state_nx = (sh_dwell == '0) ? S_STEP : S_DWELL;
      S_DWELL: if (expire) state_nx = S_STEP;
      S_STEP: begin
        if (dir_up && at_stop && !sh_pp) state_nx = S_DONE;
        else                             state_nx = (sh_dwell == '0) ? S_STEP : S_DWELL;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (stop) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      set_count  <= '0;
      sig_type   <= SINE;
      duty_cycle <= '0;
      cfg_err    <= 1'b0;
      dir_up     <= 1'b1;
      sh_sig     <= '0;
      sh_duty    <= '0;
      sh_start   <= '0;
      sh_stop    <= '0;
      sh_step    <= '0;
      sh_dwell   <= '0;
      sh_pp      <= 1'b0;
    end else begin
      state   <= state_nx;
      cfg_err <= (state == S_IDLE) && req && cfg_bad;
      if (accept) begin
        sh_sig   <= cfg_sig_type;
        sh_duty  <= cfg_duty;
        sh_start <= cfg_start_cnt;
        sh_stop  <= cfg_stop_cnt;
        sh_step  <= cfg_step;
        sh_dwell <= cfg_dwell;
        sh_pp    <= cfg_pingpong;
      end
      if (!stop) begin
        if (state == S_LOAD) begin
          set_count  <= sh_start;
          sig_type   <= sh_sig;
          duty_cycle <= sh_duty;
          dir_up     <= 1'b1;
        end else if (state == S_STEP) begin
          set_count <= step_val;
          dir_up    <= dir_nx;
        end
      end
    end
  end

  assign tmr_load = (state == S_LOAD) || (state == S_STEP);
  assign busy     = (state == S_LOAD) || (state == S_DWELL) || (state == S_STEP);
  assign done     = (state == S_DONE);

  fg_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (sh_dwell),
    .expire   (expire)
  );

endmodule

// File: tb/tb_fg_sweep_ctrl.sv
// Self-checking bench for fg_sweep_ctrl against a per-cycle trace built from the sweep rules.
module tb_fg_sweep_ctrl;
  localparam int CNT_W   = 32;
  localparam int DWELL_W = 24;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0, stop = 1'b0;
  logic [1:0]         cfg_sig_type = '0;
  logic [7:0]         cfg_duty = '0;
  logic [CNT_W-1:0]   cfg_start_cnt = '0, cfg_stop_cnt = '0, cfg_step = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic               cfg_pingpong = 1'b0;
  logic [CNT_W-1:0]   set_count;
  logic [1:0]         sig_type;
  logic [7:0]         duty_cycle;
  logic               busy, done, cfg_err;

  fg_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_sig_type(cfg_sig_type), .cfg_duty(cfg_duty),
    .cfg_start_cnt(cfg_start_cnt), .cfg_stop_cnt(cfg_stop_cnt), .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell), .cfg_pingpong(cfg_pingpong),
    .set_count(set_count), .sig_type(sig_type), .duty_cycle(duty_cycle),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sig;
    logic [7:0] duty;
    longint     s, e, st;
    int         dw;
    bit         pp;
  } cfg_t;

  typedef struct packed {
    logic [31:0] cnt;
    logic [1:0]  sig;
    logic [7:0]  duty;
    logic        busy;
    logic        done;
  } tr_t;

  int checks = 0, errors = 0;
  logic [31:0] m_cnt = '0;
  logic [1:0]  m_sig = '0;
  logic [7:0]  m_duty = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_cfg(input cfg_t c);
    cfg_sig_type  = c.sig;
    cfg_duty      = c.duty;
    cfg_start_cnt = c.s[31:0];
    cfg_stop_cnt  = c.e[31:0];
    cfg_step      = c.st[31:0];
    cfg_dwell     = DWELL_W'(c.dw);
    cfg_pingpong  = c.pp;
  endtask

  task automatic scramble_cfg();
    cfg_sig_type  = 2'($urandom);
    cfg_duty      = 8'($urandom);
    cfg_start_cnt = $urandom;
    cfg_stop_cnt  = $urandom;
    cfg_step      = $urandom;
    cfg_dwell     = DWELL_W'($urandom_range(0, 5));
    cfg_pingpong  = 1'($urandom);
  endtask

  function automatic bit cfg_ok(input cfg_t c);
    longint lim;
    lim = (c.sig == 2'd0 || c.sig == 2'd1) ? 64'd9999 : 64'd499999;
    return !(c.s > c.e || c.e > lim || c.st == 0);
  endfunction

  // Drives one start request and checks every cycle against the rule-derived trace.
  task automatic run_sweep(input cfg_t c, input int pp_cycles, input string name);
    longint vals[$];
    tr_t    tq[$];
    tr_t    t;
    longint v, nx;
    bit     up;
    int     nv;
    apply_cfg(c);
    start = 1'b1;
    tick();
    if (!cfg_ok(c)) begin
      checks++;
      if ({cfg_err, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL %s reject: got err=%0b busy=%0b done=%0b, expected err=1 busy=0 done=0", name, cfg_err, busy, done);
      end
      start = 1'b0;
      tick();
      checks++;
      if ({cfg_err, busy, set_count} !== {2'b00, m_cnt}) begin
        errors++;
        $display("FAIL %s reject_after: got err=%0b busy=%0b cnt=%0d, expected err=0 busy=0 cnt=%0d", name, cfg_err, busy, set_count, m_cnt);
      end
      return;
    end
    v  = c.s;
    up = 1'b1;
    nv = c.pp ? (pp_cycles / (c.dw + 1) + 2) : 1 << 20;
    for (int k = 0; k < nv; k++) begin
      vals.push_back(v);
      if (!c.pp && v == c.e) break;
      if (up) begin
        if (v == c.e) begin
          up = 1'b0;
          nx = (v - c.st < c.s) ? c.s : v - c.st;
        end else nx = (v + c.st > c.e) ? c.e : v + c.st;
      end else begin
        if (v == c.s) begin
          up = 1'b1;
          nx = (v + c.st > c.e) ? c.e : v + c.st;
        end else nx = (v - c.st < c.s) ? c.s : v - c.st;
      end
      v = nx;
    end
    tq.push_back('{cnt: m_cnt, sig: m_sig, duty: m_duty, busy: 1'b1, done: 1'b0});
    foreach (vals[k])
      for (int h = 0; h <= c.dw; h++)
        tq.push_back('{cnt: vals[k][31:0], sig: c.sig, duty: c.duty, busy: 1'b1, done: 1'b0});
    if (c.pp) begin
      while (tq.size() > pp_cycles + 1) void'(tq.pop_back());
    end else begin
      tq.push_back('{cnt: vals[$][31:0], sig: c.sig, duty: c.duty, busy: 1'b0, done: 1'b1});
      tq.push_back('{cnt: vals[$][31:0], sig: c.sig, duty: c.duty, busy: 1'b0, done: 1'b0});
    end
    foreach (tq[i]) begin
      t = tq[i];
      checks++;
      if ({set_count, sig_type, duty_cycle, busy, done, cfg_err} !== {t.cnt, t.sig, t.duty, t.busy, t.done, 1'b0}) begin
        errors++;
        $display("FAIL %s cycle%0d: got cnt=%0d sig=%0d duty=%0d busy=%0b done=%0b err=%0b, expected cnt=%0d sig=%0d duty=%0d busy=%0b done=%0b err=0",
                 name, i, set_count, sig_type, duty_cycle, busy, done, cfg_err, t.cnt, t.sig, t.duty, t.busy, t.done);
      end
      start = t.busy ? 1'($urandom) : 1'b0;
      scramble_cfg();
      if (i != tq.size() - 1) tick();
    end
    start = 1'b0;
    m_sig  = c.sig;
    m_duty = c.duty;
    m_cnt  = t.cnt;
    if (c.pp) begin
      stop  = 1'b1;
      start = 1'($urandom);
      tick();
      for (int r = 0; r < 2; r++) begin
        checks++;
        if ({set_count, busy, done, cfg_err} !== {m_cnt, 3'b000}) begin
          errors++;
          $display("FAIL %s stop%0d: got cnt=%0d busy=%0b done=%0b err=%0b, expected cnt=%0d busy=0 done=0 err=0",
                   name, r, set_count, busy, done, cfg_err, m_cnt);
        end
        stop  = 1'b0;
        start = 1'b0;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({set_count, sig_type, duty_cycle, busy, done, cfg_err} !== 45'd0) begin
      errors++;
      $display("FAIL reset: got cnt=%0d sig=%0d duty=%0d busy=%0b done=%0b err=%0b, expected all 0",
               set_count, sig_type, duty_cycle, busy, done, cfg_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_oneshot();
    run_sweep('{sig: 2'd0, duty: 8'd33, s: 100, e: 400, st: 100, dw: 3, pp: 1'b0}, 0, "oneshot");
    run_sweep('{sig: 2'd0, duty: 8'd77, s: 100, e: 400, st: 150, dw: 3, pp: 1'b0}, 0, "clamp");
    run_sweep('{sig: 2'd1, duty: 8'd5, s: 9990, e: 9999, st: 5, dw: 1, pp: 1'b0}, 0, "st_limit");
  endtask

  task automatic test_pingpong();
    run_sweep('{sig: 2'd2, duty: 8'd128, s: 10, e: 30, st: 10, dw: 0, pp: 1'b1}, 13, "pingpong");
    run_sweep('{sig: 2'd3, duty: 8'd200, s: 5, e: 27, st: 10, dw: 2, pp: 1'b1}, 29, "pingpong_clamp");
  endtask

  task automatic test_reject();
    run_sweep('{sig: 2'd1, duty: 8'd1, s: 0, e: 10000, st: 1, dw: 0, pp: 1'b0}, 0, "rej_limit");
    run_sweep('{sig: 2'd0, duty: 8'd1, s: 10, e: 20, st: 0, dw: 0, pp: 1'b0}, 0, "rej_step0");
    run_sweep('{sig: 2'd0, duty: 8'd1, s: 50, e: 40, st: 1, dw: 0, pp: 1'b0}, 0, "rej_order");
    run_sweep('{sig: 2'd3, duty: 8'd1, s: 0, e: 500000, st: 1, dw: 0, pp: 1'b0}, 0, "rej_sq_limit");
  endtask

  task automatic test_overflow();
    run_sweep('{sig: 2'd2, duty: 8'd9, s: 499990, e: 499999, st: 64'hFFFF_FFF0, dw: 1, pp: 1'b0}, 0, "overflow");
    run_sweep('{sig: 2'd2, duty: 8'd9, s: 499990, e: 499999, st: 64'hFFFF_FFF0, dw: 0, pp: 1'b1}, 6, "overflow_pp");
  endtask

  task automatic test_degenerate();
    run_sweep('{sig: 2'd0, duty: 8'd4, s: 77, e: 77, st: 3, dw: 2, pp: 1'b0}, 0, "degen_oneshot");
    run_sweep('{sig: 2'd0, duty: 8'd4, s: 88, e: 88, st: 3, dw: 1, pp: 1'b1}, 9, "degen_pp");
  endtask

  task automatic test_start_stop();
    apply_cfg('{sig: 2'd0, duty: 8'd90, s: 1, e: 9, st: 1, dw: 0, pp: 1'b0});
    start = 1'b1;
    stop  = 1'b1;
    tick();
    checks++;
    if ({set_count, sig_type, busy, done, cfg_err} !== {m_cnt, m_sig, 3'b000}) begin
      errors++;
      $display("FAIL start_stop: got cnt=%0d sig=%0d busy=%0b done=%0b err=%0b, expected cnt=%0d sig=%0d busy=0 done=0 err=0",
               set_count, sig_type, busy, done, cfg_err, m_cnt, m_sig);
    end
    cfg_step = '0;
    tick();
    checks++;
    if ({busy, cfg_err} !== 2'b00) begin
      errors++;
      $display("FAIL start_stop_bad: got busy=%0b err=%0b, expected busy=0 err=0", busy, cfg_err);
    end
    start = 1'b0;
    stop  = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    apply_cfg('{sig: 2'd3, duty: 8'd150, s: 1000, e: 5000, st: 100, dw: 2, pp: 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({set_count, sig_type, duty_cycle, busy, done, cfg_err} !== 45'd0) begin
      errors++;
      $display("FAIL reset_mid: got cnt=%0d sig=%0d duty=%0d busy=%0b done=%0b err=%0b, expected all 0",
               set_count, sig_type, duty_cycle, busy, done, cfg_err);
    end
    m_cnt  = '0;
    m_sig  = '0;
    m_duty = '0;
    rst_n  = 1'b1;
    tick();
  endtask

  task automatic test_random();
    cfg_t   c;
    longint lim;
    for (int n = 0; n < 24; n++) begin
      c.sig  = 2'($urandom);
      c.duty = 8'($urandom);
      c.dw   = $urandom_range(0, 3);
      c.pp   = 1'($urandom);
      c.st   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 120);
      lim    = (c.sig < 2) ? 64'd9999 : 64'd499999;
      if ($urandom_range(0, 3) == 0) begin
        c.e = lim + $urandom_range(0, 1);
        c.s = c.e - $urandom_range(0, 300);
      end else begin
        c.s = $urandom_range(0, 300);
        c.e = c.s + $urandom_range(0, 320) - 20;
        if (c.e < 0) c.e = 0;
      end
      run_sweep(c, $urandom_range(4, 40), $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_pingpong();
    test_reject();
    test_overflow();
    test_degenerate();
    test_start_stop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete within the time budget");
    $fatal(1, "timeout");
  end

endmodule
